// File: rtl/jtkiwi_rom_arb.sv
// N-channel SDRAM ROM fetch arbiter with a one-word hit cache per channel.
// Define JTKIWI_ROMARB_FIXPRIO_EN for fixed lowest-index priority; default is round-robin.
`timescale 1ns/1ps
module jtkiwi_rom_arb #(
  parameter int NCH = 3,
  parameter int AW  = 20,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NCH-1:0]    ch_cs,
  input  logic [NCH*AW-1:0] ch_addr,
  output logic [NCH-1:0]    ch_ok,
  output logic [NCH*DW-1:0] ch_data,
  output logic              sdr_req,
  output logic [AW-1:0]     sdr_addr,
  input  logic              sdr_ack,
  input  logic              sdr_rdy,
  input  logic [DW-1:0]     sdr_dout
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]               state_q, state_d;
  logic                     sdr_req_q, sdr_req_d;
  logic [AW-1:0]            sdr_addr_q, sdr_addr_d;
  logic [GW-1:0]            g_q, g_d;
  logic [NCH-1:0]           vld_q;
  logic [NCH-1:0][AW-1:0]   tag_q;
  logic [NCH-1:0][DW-1:0]   dat_q;
  logic [NCH-1:0]           miss;
  logic                     grant_vld;
  logic [GW-1:0]            grant_idx;
  logic                     fill;

  // Hits are judged purely on registered cache state, so ch_ok has no path from the SDRAM side.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_ok[gi]            = ch_cs[gi] & vld_q[gi] & (tag_q[gi] == ch_addr[gi*AW +: AW]);
      assign ch_data[gi*DW +: DW] = dat_q[gi];
    end
  endgenerate

  assign miss     = ch_cs & ~ch_ok;
  assign sdr_req  = sdr_req_q;
  assign sdr_addr = sdr_addr_q;

`ifdef JTKIWI_ROMARB_FIXPRIO_EN
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (miss[k]) begin
        grant_vld = 1'b1;
        grant_idx = GW'(k);
      end
    end
  end
`else
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] rr_idx;
  int            rr_sum;

  // Scan from farthest to nearest so the channel closest after last_q overrides the rest.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = 0;
    rr_idx    = '0;
    for (int k = NCH; k >= 1; k--) begin
      rr_sum = int'(last_q) + k;
      if (rr_sum >= NCH) rr_sum = rr_sum - NCH;
      rr_idx = GW'(rr_sum);
      if (miss[rr_idx]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    sdr_req_d  = sdr_req_q;
    sdr_addr_d = sdr_addr_q;
    g_d        = g_q;
    fill       = 1'b0;
`ifndef JTKIWI_ROMARB_FIXPRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          sdr_addr_d = ch_addr[grant_idx*AW +: AW];
          sdr_req_d  = 1'b1;
          g_d        = grant_idx;
`ifndef JTKIWI_ROMARB_FIXPRIO_EN
          last_d     = grant_idx;
`endif
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdr_ack) begin
          sdr_req_d = 1'b0;
          // Data may arrive together with the accept; fill straight away.
          if (sdr_rdy) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdr_rdy) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sdr_req_q  <= 1'b0;
      sdr_addr_q <= '0;
      g_q        <= '0;
`ifndef JTKIWI_ROMARB_FIXPRIO_EN
      last_q     <= GW'(NCH-1);
`endif
    end else begin
      state_q    <= state_d;
      sdr_req_q  <= sdr_req_d;
      sdr_addr_q <= sdr_addr_d;
      g_q        <= g_d;
`ifndef JTKIWI_ROMARB_FIXPRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  // The fill always lands tag/data; a concurrent flush keeps the entry invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
      dat_q <= '0;
    end else begin
      if (flush) vld_q <= '0;
      if (fill) begin
        tag_q[g_q] <= sdr_addr_q;
        dat_q[g_q] <= sdr_dout;
        if (!flush) vld_q[g_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtkiwi_rom_arb.sv
// Self-checking bench for jtkiwi_rom_arb: directed scenarios plus randomized traffic
// against a cache/arbitration reference model.
`timescale 1ns/1ps
module tb_jtkiwi_rom_arb;
  localparam int NCH = 3;
  localparam int AW  = 20;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [NCH-1:0]    ch_cs = '0;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_ok;
  logic [NCH*DW-1:0] ch_data;
  logic              sdr_req;
  logic [AW-1:0]     sdr_addr;
  logic              sdr_ack = 1'b0;
  logic              sdr_rdy = 1'b0;
  logic [DW-1:0]     sdr_dout = '0;

  logic [AW-1:0] a_arr[NCH];
  assign ch_addr = {a_arr[2], a_arr[1], a_arr[0]};

  int n_tests = 0;
  int n_fail  = 0;

  jtkiwi_rom_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ch_cs(ch_cs), .ch_addr(ch_addr),
    .ch_ok(ch_ok), .ch_data(ch_data), .sdr_req(sdr_req), .sdr_addr(sdr_addr),
    .sdr_ack(sdr_ack), .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_cs = '0; flush = 1'b0;
    sdr_ack = 1'b0; sdr_rdy = 1'b0; sdr_dout = '0;
    for (int i = 0; i < NCH; i++) a_arr[i] = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sdr_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Acts as the SDRAM: accept after ack_dly cycles, return data rdy_dly cycles after accept.
  task automatic serve(input int ack_dly, input int rdy_dly, input logic [DW-1:0] d,
                       input logic fl, output logic [AW-1:0] addr, output bit ok,
                       output bit stable);
    addr = '0;
    stable = 1'b1;
    wait_req(ok);
    if (!ok) return;
    addr = sdr_addr;
    repeat (ack_dly) begin
      tick();
      if (!sdr_req || sdr_addr !== addr) stable = 1'b0;
    end
    sdr_ack = 1'b1;
    if (rdy_dly == 0) begin sdr_rdy = 1'b1; sdr_dout = d; flush = fl; end
    tick();
    sdr_ack = 1'b0; sdr_rdy = 1'b0; flush = 1'b0;
    if (rdy_dly > 0) begin
      repeat (rdy_dly-1) tick();
      sdr_rdy = 1'b1; sdr_dout = d; flush = fl;
      tick();
      sdr_rdy = 1'b0; flush = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    ch_cs = 3'b111;
    #1;
    n_tests++;
    if (ch_ok !== 3'b000) begin n_fail++; $display("FAIL reset_ok got %b exp 000", ch_ok); end
    n_tests++;
    if (sdr_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", sdr_req); end
    n_tests++;
    if (sdr_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", sdr_addr); end
    n_tests++;
    if (ch_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", ch_data); end
    ch_cs = '0;
    tick();
  endtask

  task automatic test_miss_fill();
    logic [AW-1:0] ad; bit ok; bit st;
    do_reset();
    a_arr[0] = 20'h00100; ch_cs = 3'b001;
    #1;
    n_tests++;
    if (ch_ok[0] !== 1'b0) begin n_fail++; $display("FAIL miss_initial_ok got %b exp 0", ch_ok[0]); end
    serve(2, 3, 32'hDEADBEEF, 1'b0, ad, ok, st);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL miss_req_timeout got none exp sdr_req"); end
    n_tests++;
    if (ad !== 20'h00100 || !st) begin n_fail++; $display("FAIL miss_addr got %h stable %0d exp 00100", ad, st); end
    n_tests++;
    if (ch_ok[0] !== 1'b1) begin n_fail++; $display("FAIL miss_fill_ok got %b exp 1", ch_ok[0]); end
    n_tests++;
    if (ch_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_fill_data got %h exp deadbeef", ch_data[31:0]); end
    $display("[TB] fetch ch0 addr %h data %h", ad, ch_data[31:0]);
  endtask

  task automatic test_hit();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ch_ok !== 3'b001 || sdr_req !== 1'b0) begin
        n_fail++; $display("FAIL hit_cycle%0d got ok %b req %b exp ok 001 req 0", i, ch_ok, sdr_req);
      end
      tick();
    end
    ch_cs = '0;
  endtask

  task automatic test_rr_order();
    logic [AW-1:0] ad; bit ok; bit st;
    int exp_ch[4];
`ifdef JTKIWI_ROMARB_FIXPRIO_EN
    exp_ch = '{0, 0, 0, 1};
`else
    exp_ch = '{0, 1, 2, 0};
`endif
    do_reset();
    a_arr[0] = 20'h00010; a_arr[1] = 20'h00020; a_arr[2] = 20'h00030;
    ch_cs = 3'b111;
    for (int j = 0; j < 4; j++) begin
      logic [AW-1:0] exp_a;
      logic [DW-1:0] d;
      exp_a = a_arr[exp_ch[j]];
      d = 32'hA0000000 + 32'(j);
      serve(1, 1, d, 1'b0, ad, ok, st);
      n_tests++;
      if (!ok || ad !== exp_a) begin
        n_fail++; $display("FAIL arb_grant%0d got addr %h exp %h (ch%0d)", j, ad, exp_a, exp_ch[j]);
      end
      n_tests++;
      if (ch_ok[exp_ch[j]] !== 1'b1 || ch_data[exp_ch[j]*DW +: DW] !== d) begin
        n_fail++; $display("FAIL arb_fill%0d got ok %b data %h exp ch%0d data %h", j, ch_ok, ch_data[exp_ch[j]*DW +: DW], exp_ch[j], d);
      end
      $display("[TB] grant %0d ch%0d addr %h", j, exp_ch[j], ad);
`ifdef JTKIWI_ROMARB_FIXPRIO_EN
      if (j < 2) a_arr[0] = a_arr[0] + 20'd4;
`else
      if (j == 2) for (int i = 0; i < NCH; i++) a_arr[i] = a_arr[i] + 20'h01000;
`endif
    end
    ch_cs = '0;
    tick();
  endtask

  task automatic test_addr_change();
    logic [AW-1:0] ad; bit ok; bit st;
    do_reset();
    a_arr[0] = 20'h00100; ch_cs = 3'b001;
    wait_req(ok);
    n_tests++;
    if (!ok || sdr_addr !== 20'h00100) begin n_fail++; $display("FAIL chg_first_addr got %h exp 00100", sdr_addr); end
    sdr_ack = 1'b1; tick(); sdr_ack = 1'b0;
    a_arr[0] = 20'h00104;
    tick();
    sdr_rdy = 1'b1; sdr_dout = 32'hCAFEF00D;
    tick();
    sdr_rdy = 1'b0;
    n_tests++;
    if (ch_ok[0] !== 1'b0 || ch_data[31:0] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL chg_stale_fill got ok %b data %h exp ok 0 data cafef00d", ch_ok[0], ch_data[31:0]);
    end
    tick();
    n_tests++;
    if (sdr_req !== 1'b1 || sdr_addr !== 20'h00104) begin
      n_fail++; $display("FAIL chg_refetch got req %b addr %h exp req 1 addr 00104", sdr_req, sdr_addr);
    end
    serve(0, 1, 32'h01040104, 1'b0, ad, ok, st);
    n_tests++;
    if (ch_ok[0] !== 1'b1 || ch_data[31:0] !== 32'h01040104) begin
      n_fail++; $display("FAIL chg_second_fill got ok %b data %h exp ok 1 data 01040104", ch_ok[0], ch_data[31:0]);
    end
    ch_cs = '0;
    tick();
  endtask

  task automatic test_flush_fill();
    logic [AW-1:0] ad; bit ok; bit st;
    do_reset();
    a_arr[0] = 20'h00300; ch_cs = 3'b001;
    serve(1, 2, 32'h11112222, 1'b1, ad, ok, st);
    n_tests++;
    if (!ok || ch_ok[0] !== 1'b0 || ch_data[31:0] !== 32'h11112222) begin
      n_fail++; $display("FAIL flush_fill got ok %b data %h exp ok 0 data 11112222", ch_ok[0], ch_data[31:0]);
    end
    tick();
    n_tests++;
    if (sdr_req !== 1'b1 || sdr_addr !== 20'h00300) begin
      n_fail++; $display("FAIL flush_refetch got req %b addr %h exp req 1 addr 00300", sdr_req, sdr_addr);
    end
    serve(0, 0, 32'h33334444, 1'b0, ad, ok, st);
    n_tests++;
    if (ch_ok[0] !== 1'b1 || ch_data[31:0] !== 32'h33334444) begin
      n_fail++; $display("FAIL same_cycle_fill got ok %b data %h exp ok 1 data 33334444", ch_ok[0], ch_data[31:0]);
    end
    ch_cs = '0; flush = 1'b1; tick(); flush = 1'b0;
    ch_cs = 3'b001; #1;
    n_tests++;
    if (ch_ok[0] !== 1'b0) begin n_fail++; $display("FAIL idle_flush got ok %b exp 0", ch_ok[0]); end
    ch_cs = '0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    logic [AW-1:0] ad; bit ok; bit st;
    do_reset();
    a_arr[0] = 20'h00200; ch_cs = 3'b001;
    wait_req(ok);
    sdr_ack = 1'b1; tick(); sdr_ack = 1'b0;
    rst = 1'b1; ch_cs = '0; tick(); rst = 1'b0;
    sdr_rdy = 1'b1; sdr_dout = 32'h55555555; tick(); sdr_rdy = 1'b0;
    n_tests++;
    if (sdr_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req got %b exp 0", sdr_req); end
    ch_cs = 3'b001; #1;
    n_tests++;
    if (ch_ok[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_fill got ok %b exp 0", ch_ok[0]); end
    tick();
    n_tests++;
    if (sdr_req !== 1'b1 || sdr_addr !== 20'h00200) begin
      n_fail++; $display("FAIL rstmid_refetch got req %b addr %h exp req 1 addr 00200", sdr_req, sdr_addr);
    end
    serve(0, 1, 32'h20020002, 1'b0, ad, ok, st);
    n_tests++;
    if (ch_ok[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_final got ok %b exp 1", ch_ok[0]); end
    ch_cs = '0;
    tick();
  endtask

  task automatic test_random();
    bit            m_vld[NCH];
    logic [AW-1:0] m_tag[NCH];
    logic [DW-1:0] m_dat[NCH];
    int            m_last;
    logic [AW-1:0] ad; bit ok; bit st;
    do_reset();
    for (int i = 0; i < NCH; i++) begin m_vld[i] = 1'b0; m_tag[i] = '0; m_dat[i] = '0; end
    m_last = NCH-1;
    for (int it = 0; it < 150; it++) begin
      logic [NCH-1:0] exp_ok;
      int g;
      if ($urandom_range(7) == 0) begin
        ch_cs = '0; flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < NCH; i++) m_vld[i] = 1'b0;
      end
      ch_cs = NCH'($urandom);
      for (int i = 0; i < NCH; i++) a_arr[i] = 20'h00400 + 20'($urandom_range(3)) * 20'd4;
      #1;
      for (int i = 0; i < NCH; i++) exp_ok[i] = ch_cs[i] && m_vld[i] && (m_tag[i] == a_arr[i]);
      n_tests++;
      if (ch_ok !== exp_ok) begin n_fail++; $display("FAIL rnd%0d_ok got %b exp %b", it, ch_ok, exp_ok); end
      for (int i = 0; i < NCH; i++) begin
        if (exp_ok[i]) begin
          n_tests++;
          if (ch_data[i*DW +: DW] !== m_dat[i]) begin
            n_fail++; $display("FAIL rnd%0d_hitdata ch%0d got %h exp %h", it, i, ch_data[i*DW +: DW], m_dat[i]);
          end
        end
      end
      g = -1;
`ifdef JTKIWI_ROMARB_FIXPRIO_EN
      for (int k = 0; k < NCH && g < 0; k++)
        if (ch_cs[k] && !exp_ok[k]) g = k;
`else
      for (int k = 1; k <= NCH && g < 0; k++)
        if (ch_cs[(m_last + k) % NCH] && !exp_ok[(m_last + k) % NCH]) g = (m_last + k) % NCH;
`endif
      tick();
      if (g < 0) begin
        n_tests++;
        if (sdr_req !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_idle_req got %b exp 0", it, sdr_req); end
        $display("[TB] rnd %0d cs %b all hit", it, ch_cs);
      end else begin
        logic [DW-1:0] d;
        logic [AW-1:0] exp_a;
        d = $urandom;
        exp_a = a_arr[g];
        n_tests++;
        if (sdr_req !== 1'b1 || sdr_addr !== exp_a) begin
          n_fail++; $display("FAIL rnd%0d_grant got req %b addr %h exp req 1 addr %h (ch%0d)", it, sdr_req, sdr_addr, exp_a, g);
        end
        serve($urandom_range(3), $urandom_range(3), d, 1'b0, ad, ok, st);
        n_tests++;
        if (!ok || !st) begin n_fail++; $display("FAIL rnd%0d_handshake got ok %0d stable %0d exp 1 1", it, ok, st); end
        m_vld[g] = 1'b1; m_tag[g] = exp_a; m_dat[g] = d; m_last = g;
        n_tests++;
        if (ch_ok[g] !== 1'b1 || ch_data[g*DW +: DW] !== d) begin
          n_fail++; $display("FAIL rnd%0d_fill ch%0d got ok %b data %h exp ok 1 data %h", it, g, ch_ok[g], ch_data[g*DW +: DW], d);
        end
        $display("[TB] rnd %0d cs %b fetch ch%0d addr %h data %h", it, ch_cs, g, exp_a, d);
      end
    end
    ch_cs = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_rr_order();
    test_addr_change();
    test_flush_fill();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
